dual_port_mem: RTL and testbench
================================

Name: dual_port_mem

Overview:
- Parametrised successor of the single-port instruction/data memory.
- One read-only instruction port (I) and one read/write data port (D) share a single storage array.
- Reads are registered (1-cycle latency). D-port writes support byte enables.
- After reset, an internal clear sequencer initialises every word before ports are serviced; no file loading.

Parameters:
- DSIZE, 32, data word width in bits; must be a multiple of 8.
- ASIZE, 10, word-address width; depth = 2**ASIZE words.
- INIT_VAL, 0, value written to every word by the clear sequencer.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset, sampled on posedge clk.
- i_req  input  1  instruction read request.
- i_addr  input  ASIZE  instruction word address.
- i_rdata  output  DSIZE  instruction read data.
- i_rvalid  output  1  i_rdata valid this cycle.
- d_req  input  1  data access request.
- d_wen  input  1  1 = write, 0 = read; meaningful only with d_req.
- d_be  input  DSIZE/8  byte enables for writes; bit k covers bits [8k+7:8k].
- d_addr  input  ASIZE  data word address.
- d_wdata  input  DSIZE  write data.
- d_rdata  output  DSIZE  data read data.
- d_rvalid  output  1  d_rdata valid this cycle.
- ready  output  1  array initialised; requests accepted.

Behaviour:
- Reset (rst=0 at posedge):
  - FSM enters CLEAR and the clear counter is set to 0.
  - Outputs: ready=0, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0.
  - Array contents are not modified by reset itself.
- FSM states:
  - CLEAR: each cycle writes INIT_VAL to array[counter], then counter+1. When counter = 2**ASIZE-1 is written, the next state is READY. CLEAR takes exactly 2**ASIZE cycles; ready rises on the following edge.
  - READY: normal operation. Leaves READY only on reset.
- Reset mid-CLEAR restarts the counter at 0; the full sweep is repeated.
- In CLEAR, i_req and d_req are ignored:
  - no array write from port D; rvalid outputs stay 0;
  - requesters must hold or reissue once ready=1.
- I read (READY, i_req=1): at the next edge, i_rdata = array[i_addr] and i_rvalid=1. Otherwise i_rvalid=0 and i_rdata holds its last value.
- D read (READY, d_req=1, d_wen=0): same timing on d_rdata/d_rvalid.
- D write (READY, d_req=1, d_wen=1):
  - at the edge, each enabled byte of array[d_addr] takes d_wdata; disabled bytes are unchanged;
  - d_rvalid=0 the next cycle;
  - d_be=0 is a legal no-op.
- Same-cycle collision (I read and D write to the same address): i_rdata returns the merged new word. Enabled bytes come from d_wdata; others from the old array value (write-first bypass).
- Different addresses: both ports are serviced in the same cycle with no stall.
- Addresses wrap naturally: no out-of-range condition exists, since depth = 2**ASIZE.
- No X may reach outputs after reset.

Test Plan:
- ASIZE=4, DSIZE=32, INIT_VAL=32'hDEADBEEF; hold rst=0 one cycle, release -> ready=0 for 16 cycles, ready=1 on cycle 17; a D read of every address returns 32'hDEADBEEF, each 1 cycle after request.
- After ready: write d_addr=3, d_wdata=32'h11223344, d_be=4'b1111; next cycle i_req, i_addr=3 -> i_rdata=32'h11223344, i_rvalid=1 exactly one cycle after the request.
- Byte enables: word 5 = 32'hAABBCCDD; write 32'h00112233 with d_be=4'b0101 -> a read of word 5 returns 32'hAA11CC33.
- Collision: word 7 = 32'h0; same cycle, D writes 32'hFFFF0000 with be=4'b1100 and I reads address 7 -> i_rdata=32'hFFFF0000 next cycle.
- Requests during CLEAR: d_req=1, d_wen=1, d_addr=2, d_wdata=32'h5 issued at clear cycle 4 -> no rvalid pulses; after ready, word 2 = INIT_VAL.
- Reset mid-CLEAR: assert rst=0 at clear cycle 10 -> ready stays 0 for a full 16 cycles after release, and all words equal INIT_VAL.

Source files
------------

// File: rtl/dual_port_mem.sv
// Dual-port word memory: read-only instruction port (I) and read/write data
// port (D) sharing one array. Registered reads, byte-enabled D writes,
// write-first bypass from D to I on same-address collisions, and a clear
// sweep after reset that fills every word with INIT_VAL before ports open.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | sweeping INIT_VAL into array[cnt]; all port requests ignored
// S_READY | normal operation; left only through reset
module dual_port_mem #(
    parameter int               DSIZE    = 32,
    parameter int               ASIZE    = 10,
    parameter logic [DSIZE-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ASIZE-1:0]     i_addr,
    output logic [DSIZE-1:0]     i_rdata,
    output logic                 i_rvalid,
    input  logic                 d_req,
    input  logic                 d_wen,
    input  logic [DSIZE/8-1:0]   d_be,
    input  logic [ASIZE-1:0]     d_addr,
    input  logic [DSIZE-1:0]     d_wdata,
    output logic [DSIZE-1:0]     d_rdata,
    output logic                 d_rvalid,
    output logic                 ready
);

    localparam int               NB      = DSIZE / 8;
    localparam int               DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE-1:0] CNT_MAX = '1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t               state;
    logic [ASIZE-1:0]     cnt;
    logic [DSIZE-1:0]     mem [DEPTH];
    logic [DSIZE-1:0]     i_merged;
    logic                 d_write;
    logic                 i_bypass;

    // ready lags the READY state by one edge, so ports only open once the
    // final clear write has landed in the array.
    assign d_write  = ready && d_req && d_wen;
    assign i_bypass = d_write && (d_addr == i_addr);

    // Word the I port would see if the concurrent D write landed first.
    always_comb begin
        i_merged = mem[i_addr];
        for (int k = 0; k < NB; k++) begin
            if (d_be[k]) i_merged[8*k +: 8] = d_wdata[8*k +: 8];
        end
    end

    // Clear sequencer, ready flag and registered read ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            ready    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            if (state == S_CLEAR) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_MAX) state <= S_READY;
            end
            ready    <= (state == S_READY);
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (ready && i_req) begin
                i_rvalid <= 1'b1;
                i_rdata  <= i_bypass ? i_merged : mem[i_addr];
            end
            if (ready && d_req && !d_wen) begin
                d_rvalid <= 1'b1;
                d_rdata  <= mem[d_addr];
            end
        end
    end

    // Array writes: clear sweep first, then byte-enabled D-port writes.
    // The reset cycle itself leaves the array untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= INIT_VAL;
            end else if (d_write) begin
                for (int k = 0; k < NB; k++) begin
                    if (d_be[k]) mem[d_addr][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_port_mem.sv
// Directed bench for dual_port_mem with a 16-word array and a non-zero
// clear value, so cleared words are distinguishable from reset outputs.
module tb_dual_port_mem;

    localparam int          DSIZE = 32;
    localparam int          ASIZE = 4;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ASIZE-1:0]  i_addr;
    logic [DSIZE-1:0]  i_rdata;
    logic              i_rvalid;
    logic              d_req;
    logic              d_wen;
    logic [3:0]        d_be;
    logic [ASIZE-1:0]  d_addr;
    logic [DSIZE-1:0]  d_wdata;
    logic [DSIZE-1:0]  d_rdata;
    logic              d_rvalid;
    logic              ready;

    int errors = 0;
    int checks = 0;

    dual_port_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE), .INIT_VAL(INIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_wen(d_wen), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs driven 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_wen = 0; d_be = 4'h0;
    endtask

    task automatic d_write(input logic [ASIZE-1:0] a, input logic [31:0] w, input logic [3:0] be);
        d_req = 1; d_wen = 1; d_addr = a; d_wdata = w; d_be = be;
    endtask

    task automatic d_read(input logic [ASIZE-1:0] a);
        d_req = 1; d_wen = 0; d_addr = a; d_be = 4'h0;
    endtask

    initial begin
        int low;
        int rv_seen;
        int got_ready;

        rst = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        idle();
        tick();
        check("rst_ready",    {31'd0, ready},    32'd0);
        check("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rst_i_rdata",  i_rdata,           32'd0);
        check("rst_d_rdata",  d_rdata,           32'd0);

        // Partial sweep, then reset at clear cycle 10.
        rst = 1;
        low = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!ready) low++;
        end
        check("partial_low", low, 10);
        rst = 0;
        tick();
        check("midrst_ready", {31'd0, ready}, 32'd0);
        rst = 1;

        // Full sweep with requests injected at clear cycle 4.
        low = 0; rv_seen = 0; got_ready = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin
                d_write(4'd2, 32'h5, 4'hF);
                i_req = 1; i_addr = 4'd2;
            end else begin
                idle();
            end
            tick();
            if (i_rvalid || d_rvalid) rv_seen++;
            if (ready) begin
                got_ready = i;
                break;
            end
            low++;
        end
        idle();
        check("clear_low_cycles", low, 16);
        check("ready_cycle", got_ready, 17);
        check("clear_no_rvalid", rv_seen, 0);

        // Every word holds INIT, one cycle after each request.
        for (int a = 0; a < 16; a++) begin
            d_read(a[ASIZE-1:0]);
            tick();
            check($sformatf("init_rv_%0d", a), {31'd0, d_rvalid}, 32'd1);
            check($sformatf("init_rd_%0d", a), d_rdata, INIT);
        end
        idle();
        tick();
        check("idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("idle_d_hold",   d_rdata,           INIT);

        // Full write then I read.
        d_write(4'd3, 32'h11223344, 4'hF);
        tick();
        check("wr3_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        idle();
        i_req = 1; i_addr = 4'd3;
        tick();
        check("i3_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("i3_rdata",  i_rdata,           32'h11223344);
        idle();
        tick();
        check("i3_rvalid_off", {31'd0, i_rvalid}, 32'd0);
        check("i3_hold",       i_rdata,           32'h11223344);

        // Byte enables, with a concurrent I read of another address.
        d_write(4'd5, 32'hAABBCCDD, 4'hF);
        tick();
        d_write(4'd5, 32'h00112233, 4'b0101);
        tick();
        d_read(4'd5);
        i_req = 1; i_addr = 4'd3;
        tick();
        check("be5_rdata",  d_rdata,           32'hAA11CC33);
        check("be5_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("par_i3",     i_rdata,           32'h11223344);
        check("par_i3_rv",  {31'd0, i_rvalid}, 32'd1);
        idle();

        // Same-address collision: I sees the merged new word.
        d_write(4'd7, 32'h0, 4'hF);
        tick();
        d_write(4'd7, 32'hFFFF0000, 4'b1100);
        i_req = 1; i_addr = 4'd7;
        tick();
        check("col_i_rdata",  i_rdata,           32'hFFFF0000);
        check("col_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("col_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        idle();

        // Partial collision merge keeps unwritten bytes of the old word.
        d_write(4'd7, 32'h0000ABCD, 4'b0001);
        i_req = 1; i_addr = 4'd7;
        tick();
        check("col2_i_rdata", i_rdata, 32'hFFFF00CD);
        idle();

        // d_be = 0 is a no-op write.
        d_write(4'd7, 32'h12345678, 4'h0);
        tick();
        d_read(4'd7);
        tick();
        check("be0_noop", d_rdata, 32'hFFFF00CD);
        idle();

        // Untouched neighbour keeps INIT.
        d_read(4'd6);
        tick();
        check("word6_init", d_rdata, INIT);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
